// File: rtl/ternary_pkg.sv
// Shared types, code constants and helpers for the ternary weight loader.
// Build option: TERNARY_WLOAD_DBUF_EN selects the double-buffered weight array.
package ternary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSB  = 2'd1,
        ST_LSB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Weight codes are {msb, lsb}
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_INV  = 2'b10;

    localparam int MAX_IN_LEN_DEF  = 16;
    localparam int MAX_OUT_LEN_DEF = 8;
    localparam int COL_W = $clog2(MAX_IN_LEN_DEF);
    localparam int ROW_W = $clog2(MAX_OUT_LEN_DEF);

    function automatic logic is_invalid(input logic [1:0] code);
        return code == W_INV;
    endfunction

endpackage

// File: rtl/ternary_row_assemble.sv
// Combines one msb and one lsb bit-plane into a row of 2-bit ternary codes,
// zeroing masked columns and flagging invalid codes in active columns.
module ternary_row_assemble
    import ternary_pkg::*;
#(
    parameter int N = MAX_IN_LEN_DEF
) (
    input  logic [N-1:0]         msb,
    input  logic [N-1:0]         lsb,
    input  logic [$clog2(N)-1:0] in_last,
    output logic [2*N-1:0]       codes,
    output logic                 invalid
);

    always_comb begin
        codes   = '0;
        invalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i <= int'(in_last)) begin
                case ({msb[i], lsb[i]})
                    W_POS, W_NEG: codes[2*i +: 2] = {msb[i], lsb[i]};
                    default:      codes[2*i +: 2] = W_ZERO;
                endcase
                if (is_invalid({msb[i], lsb[i]}))
                    invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ternary_weight_loader.sv
// Loads a MAX_IN_LEN x MAX_OUT_LEN ternary weight array from msb/lsb bit-plane beats.
// Build option: TERNARY_WLOAD_DBUF_EN (shadow array, atomic update at completion).
//
// Handshake: a beat is transferred on a rising edge where in_valid && in_ready;
// in_ready depends only on state, and start takes priority over a beat in the same cycle.
module ternary_weight_loader
    import ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
    parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(MAX_IN_LEN)-1:0]          cfg_in_last,
    input  logic [$clog2(MAX_OUT_LEN)-1:0]         cfg_out_last,
    input  logic [MAX_IN_LEN-1:0]                  in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]    uo_weights,
    output logic                                   uo_done,
    output logic                                   uo_busy,
    output logic                                   uo_err,
    output logic [$clog2(MAX_OUT_LEN)-1:0]         uo_row,
    output logic [1:0]                             dbg_state
);

    localparam int IW = $clog2(MAX_IN_LEN);
    localparam int RW = $clog2(MAX_OUT_LEN);
    localparam int WB = 2*MAX_IN_LEN*MAX_OUT_LEN;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q;
    logic [RW-1:0]         cfg_out_q;
    logic [IW-1:0]         cfg_in_q;
    logic [MAX_IN_LEN-1:0] msb_q;
    logic                  err_q;
    logic [WB-1:0]         weights_q;
    logic [WB-1:0]         base;
    logic [WB-1:0]         merged;
    logic [2*MAX_IN_LEN-1:0] row_codes;
    logic                  row_inv;
    logic                  last_row;

    ternary_row_assemble #(.N(MAX_IN_LEN)) u_row (
        .msb     (msb_q),
        .lsb     (in_data),
        .in_last (cfg_in_q),
        .codes   (row_codes),
        .invalid (row_inv)
    );

    assign last_row = (row_q == cfg_out_q);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        uo_busy  = 1'b0;
        uo_done  = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_MSB: begin
                in_ready = 1'b1;
                uo_busy  = 1'b1;
                if (in_valid)
                    state_d = ST_LSB;
            end
            ST_LSB: begin
                in_ready = 1'b1;
                uo_busy  = 1'b1;
                if (in_valid)
                    state_d = last_row ? ST_DONE : ST_MSB;
            end
            ST_DONE: begin
                uo_busy = 1'b1;
                uo_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start)
            state_d = ST_MSB;
    end

`ifdef TERNARY_WLOAD_DBUF_EN
    logic [WB-1:0] shadow_q;
    assign base = shadow_q;
`else
    assign base = weights_q;
`endif

    // Current row overlaid on whichever array is being assembled.
    always_comb begin
        merged = base;
        for (int i = 0; i < MAX_IN_LEN; i++)
            merged[2*(i*MAX_OUT_LEN + int'(row_q)) +: 2] = row_codes[2*i +: 2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            cfg_out_q <= '0;
            cfg_in_q  <= '0;
            msb_q     <= '0;
            err_q     <= 1'b0;
            weights_q <= '0;
`ifdef TERNARY_WLOAD_DBUF_EN
            shadow_q  <= '0;
`endif
        end else if (start) begin
            cfg_in_q  <= cfg_in_last;
            cfg_out_q <= cfg_out_last;
            row_q     <= '0;
            err_q     <= 1'b0;
`ifdef TERNARY_WLOAD_DBUF_EN
            // Untouched rows must keep the currently visible contents.
            shadow_q  <= weights_q;
`endif
        end else if (state_q == ST_MSB && in_valid) begin
            msb_q <= in_data;
        end else if (state_q == ST_LSB && in_valid) begin
            err_q <= err_q | row_inv;
            if (!last_row)
                row_q <= row_q + 1'b1;
`ifdef TERNARY_WLOAD_DBUF_EN
            shadow_q <= merged;
            if (last_row)
                weights_q <= merged;
`else
            weights_q <= merged;
`endif
        end
    end

    assign uo_weights = weights_q;
    assign uo_err     = err_q;
    assign uo_row     = row_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Randomized self-checking bench for ternary_weight_loader against a per-weight reference model.
module tb_ternary_weight_loader;
  import ternary_pkg::*;

  localparam int IN_LEN  = 16;
  localparam int OUT_LEN = 8;
  localparam int WB      = 2*IN_LEN*OUT_LEN;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [COL_W-1:0] cfg_in_last;
  logic [ROW_W-1:0] cfg_out_last;
  logic [IN_LEN-1:0] in_data;
  logic in_ready, uo_done, uo_busy, uo_err;
  logic [WB-1:0] uo_weights;
  logic [ROW_W-1:0] uo_row;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // reference: signed weight values per [row][col]
  int ref_vis[OUT_LEN][IN_LEN];
  int ref_sh[OUT_LEN][IN_LEN];
  bit ref_err;

  ternary_weight_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_last(cfg_in_last), .cfg_out_last(cfg_out_last),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .uo_weights(uo_weights), .uo_done(uo_done), .uo_busy(uo_busy),
    .uo_err(uo_err), .uo_row(uo_row), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model
  function automatic logic [WB-1:0] pack_ref();
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < OUT_LEN; r++)
      for (int i = 0; i < IN_LEN; i++)
        case (ref_vis[r][i])
          1:       v[2*(i*OUT_LEN + r) +: 2] = 2'b01;
          -1:      v[2*(i*OUT_LEN + r) +: 2] = 2'b11;
          default: v[2*(i*OUT_LEN + r) +: 2] = 2'b00;
        endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < OUT_LEN; r++)
      for (int i = 0; i < IN_LEN; i++) begin
        ref_vis[r][i] = 0;
        ref_sh[r][i] = 0;
      end
    ref_err = 1'b0;
  endtask

  task automatic model_row(input int r, input int in_last, input logic [IN_LEN-1:0] m,
                           input logic [IN_LEN-1:0] l, input bit last);
    int row_v[IN_LEN];
    for (int i = 0; i < IN_LEN; i++) begin
      row_v[i] = 0;
      if (i <= in_last) begin
        if (m[i] && l[i]) row_v[i] = -1;
        else if (!m[i] && l[i]) row_v[i] = 1;
        else if (m[i] && !l[i]) ref_err = 1'b1;
      end
    end
`ifdef TERNARY_WLOAD_DBUF_EN
    ref_sh[r] = row_v;
    if (last) ref_vis = ref_sh;
`else
    ref_vis[r] = row_v;
`endif
  endtask

  // drivers
  task automatic do_start(input int out_last, input int in_last);
    start = 1'b1;
    in_valid = 1'b0;
    cfg_out_last = ROW_W'(out_last);
    cfg_in_last = COL_W'(in_last);
    @(negedge clk);
    start = 1'b0;
    ref_sh = ref_vis;
    ref_err = 1'b0;
    // cfg must have been latched; scramble the live inputs
    cfg_out_last = ROW_W'($urandom);
    cfg_in_last = COL_W'($urandom);
    check("start_busy", WB'(uo_busy), WB'(1));
    check("start_err_clear", WB'(uo_err), WB'(0));
    check("start_row", WB'(uo_row), WB'(0));
  endtask

  task automatic send_beat(input logic [IN_LEN-1:0] d, input int idle_pct);
    int guard;
    while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
      in_valid = 1'b0;
      in_data = IN_LEN'($urandom);
      @(negedge clk);
    end
    in_data = d;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", WB'(in_ready), WB'(1));
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load(input int out_last, input int in_last, input int idle_pct, input bit rnd,
                         input logic [IN_LEN-1:0] mp, input logic [IN_LEN-1:0] lp, input int nbeats);
    logic [IN_LEN-1:0] m, l;
    bit last;
    do_start(out_last, in_last);
    m = '0;
    for (int b = 0; b < nbeats; b++) begin
      if (b % 2 == 0) begin
        m = rnd ? IN_LEN'($urandom) : mp;
        send_beat(m, idle_pct);
        check("done_low_msb", WB'(uo_done), WB'(0));
      end else begin
        l = rnd ? IN_LEN'($urandom) : lp;
        last = (b / 2 == out_last);
        send_beat(l, idle_pct);
        model_row(b / 2, in_last, m, l, last);
        check("weights_row", uo_weights, pack_ref());
        check("done_pulse", WB'(uo_done), WB'(last));
        if (!last) check("row_index", WB'(uo_row), WB'(b / 2 + 1));
      end
    end
    if (nbeats == 2*(out_last + 1)) begin
      check("err_final", WB'(uo_err), WB'(ref_err));
      @(negedge clk);
      check("done_one_cycle", WB'(uo_done), WB'(0));
      check("idle_busy", WB'(uo_busy), WB'(0));
      check("weights_hold", uo_weights, pack_ref());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_in_last = '0; cfg_out_last = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_weights", uo_weights, '0);
    check("reset_flags", WB'({uo_done, uo_busy, uo_err, in_ready}), WB'(0));
    check("reset_row", WB'(uo_row), WB'(0));

    // full array of -1
    do_load(7, 15, 0, 1'b0, 16'hFFFF, 16'hFFFF, 16);
    // partial rows and masked columns
    do_load(2, 3, 0, 1'b0, 16'h000F, 16'hFFFF, 6);
    // invalid code in row 0, sticky until next start
    do_load(0, 15, 0, 1'b0, 16'h0001, 16'h0000, 2);
    // beats offered while idle are ignored
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = IN_LEN'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("idle_ignore_weights", uo_weights, pack_ref());
    check("idle_ignore_busy", WB'(uo_busy), WB'(0));
    check("err_sticky", WB'(uo_err), WB'(1));
    // throttled stream, same -1 image
    do_load(7, 15, 30, 1'b0, 16'hFFFF, 16'hFFFF, 16);
    // random configurations and data
    for (int n = 0; n < 6; n++) begin
      int ol, il;
      ol = $urandom_range(OUT_LEN - 1);
      il = $urandom_range(IN_LEN - 1);
      do_load(ol, il, 25, 1'b1, '0, '0, 2*(ol + 1));
    end
    // abort after 3 beats, then a full new load
    do_load(7, 15, 0, 1'b1, '0, '0, 3);
    do_load(7, 15, 10, 1'b1, '0, '0, 16);
    // reset while in LSB of row 4
    do_load(7, 15, 0, 1'b1, '0, '0, 9);
    check("row_before_rst", WB'(uo_row), WB'(4));
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("rst_weights", uo_weights, pack_ref());
    check("rst_flags", WB'({uo_busy, in_ready, uo_done, uo_err}), WB'(0));
    rst = 1'b0;
    @(negedge clk);
    do_load(1, 7, 20, 1'b1, '0, '0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
